// File: rtl/pattern_det_pkg.sv
// Shared defaults for the pattern detector slice.
// Optional build macro PATTERN_DET_SYNC_EN enables the input synchronizer.
package pattern_det_pkg;

    localparam int         DEFAULT_WIDTH   = 4;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1000;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for a slow level signal; one-cycle rise_out per low-to-high change.
// Build macro PATTERN_DET_SYNC_EN inserts a 2-flop synchronizer ahead of the edge flop.
module rise_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise_out
);

    logic w_sig;
    logic r_sigQ;

`ifdef PATTERN_DET_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sig = r_sync2;
`else
    assign w_sig = sig_in;
`endif

    // Clearing the history flop on reset makes a level held high through reset count as a rise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sigQ <= 1'b0;
        end else begin
            r_sigQ <= w_sig;
        end
    end

    assign rise_out = w_sig & ~r_sigQ;

endmodule

// File: rtl/pattern_detector_pulse.sv
// Emits one registered match pulse per enable rise when data_in equals PATTERN.
// Build macro PATTERN_DET_SYNC_EN synchronizes enable and delays data_in to stay aligned.
module pattern_detector_pulse
    import pattern_det_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic             match_pulse
);

    logic             w_rise;
    logic [WIDTH-1:0] w_data;
    logic             r_match;

    rise_edge_detect u_riseDetect (
        .clk      (clk),
        .reset    (reset),
        .sig_in   (enable),
        .rise_out (w_rise)
    );

`ifdef PATTERN_DET_SYNC_EN
    // Two data stages mirror the synchronizer depth so the word compared is the one present at the rise.
    logic [WIDTH-1:0] r_data1;
    logic [WIDTH-1:0] r_data2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data1 <= '0;
            r_data2 <= '0;
        end else begin
            r_data1 <= data_in;
            r_data2 <= r_data1;
        end
    end

    assign w_data = r_data2;
`else
    assign w_data = data_in;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_rise && (w_data == PATTERN);
        end
    end

    assign match_pulse = r_match;

endmodule

// File: tb/tb_pattern_detector_pulse.sv
// Directed, table-driven bench for pattern_detector_pulse in its default build.
module tb_pattern_detector_pulse;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] data_in;
    logic       match_pulse;

    int compareCount = 0;
    int failCount    = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] data;
        logic       expMatch;
        string      name;
    } vec_t;

    vec_t vecs[$];

    pattern_detector_pulse #(
        .WIDTH   (4),
        .PATTERN (4'b1000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .data_in     (data_in),
        .match_pulse (match_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(logic rst, logic en, logic [3:0] data, logic expMatch, string name);
        vec_t v;
        v.rst      = rst;
        v.en       = en;
        v.data     = data;
        v.expMatch = expMatch;
        v.name     = name;
        vecs.push_back(v);
    endfunction

    // Inputs are driven 1 time unit after an edge and take effect at the next edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] data);
        reset   = rst;
        enable  = en;
        data_in = data;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expMatch);
        compareCount++;
        if (match_pulse !== expMatch) begin
            failCount++;
            $display("[TB] FAIL %s: match_pulse got %b, expected %b at %0t", name, match_pulse, expMatch, $time);
        end
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        data_in = 4'bxxxx;

        for (int i = 0; i < 5; i++) addVec(1'b0, 1'b0, 4'bxxxx, 1'b0, "reset_hold");
        addVec(1'b1, 1'b0, 4'b1000, 1'b0, "first_edge_after_release");
        addVec(1'b1, 1'b1, 4'b1000, 1'b1, "rise_match_pulse");
        addVec(1'b1, 1'b0, 4'b1000, 1'b0, "pulse_one_cycle");
        addVec(1'b1, 1'b1, 4'b1001, 1'b0, "rise_mismatch");
        addVec(1'b1, 1'b0, 4'b1001, 1'b0, "mismatch_after");
        for (int i = 0; i < 3; i++) addVec(1'b1, 1'b0, 4'b1000, 1'b0, "enable_low_pattern");
        addVec(1'b1, 1'b1, 4'b1000, 1'b1, "held_first_pulse");
        addVec(1'b1, 1'b1, 4'b1000, 1'b0, "held_no_repeat");
        addVec(1'b1, 1'b1, 4'bxxxx, 1'b0, "held_data_x");
        addVec(1'b1, 1'b1, 4'b1000, 1'b0, "held_no_repeat");
        addVec(1'b1, 1'b1, 4'b1000, 1'b0, "held_no_repeat");
        addVec(1'b1, 1'b0, 4'b1000, 1'b0, "enable_drop");
        addVec(1'b1, 1'b1, 4'b1000, 1'b1, "second_rise_pulse");
        addVec(1'b1, 1'b0, 4'b1000, 1'b0, "second_pulse_end");
        addVec(1'b1, 1'b1, 4'b1001, 1'b0, "mismatch_rise");
        addVec(1'b1, 1'b1, 4'b1000, 1'b0, "no_retry_same_high");
        addVec(1'b1, 1'b0, 4'b1000, 1'b0, "drop_after_retry");
        addVec(1'b1, 1'b1, 4'b0000, 1'b0, "rise_zero_word");
        addVec(1'b1, 1'b1, 4'b1000, 1'b0, "data_change_while_high");
        addVec(1'b1, 1'b0, 4'b0000, 1'b0, "final_drop");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].data);
            checkOutput(vecs[i].name, vecs[i].expMatch);
        end

        // Enable rising while reset is asserted, then held high through the release.
        applyStimulus(1'b0, 1'b1, 4'b1000);
        checkOutput("rise_during_reset", 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b1000);
        checkOutput("held_during_reset", 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b1000);
        checkOutput("held_through_release", 1'b1);
        applyStimulus(1'b1, 1'b1, 4'b1000);
        checkOutput("held_after_release", 1'b0);

        // Reset asserted on the cycle right after a pulse.
        applyStimulus(1'b1, 1'b0, 4'b1000);
        checkOutput("pre_pulse_low", 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b1000);
        checkOutput("pulse_before_reset", 1'b1);
        applyStimulus(1'b0, 1'b1, 4'b1000);
        checkOutput("reset_clears_pulse", 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b1000);
        checkOutput("rise_after_reset_clear", 1'b1);
        applyStimulus(1'b1, 1'b0, 4'b0111);
        checkOutput("tail_low", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
